// File: rtl/wb_arbiter_if.sv
// Result-bus bundle between the ALU/load units, the write-back arbiter and the register file.
// The master drives results and flush; the slave (wb_arbiter) drives readies and the write port.
interface wb_arbiter_if;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_rd;
    logic [63:0] alu_val;
    logic        ld_valid;
    logic        ld_ready;
    logic [4:0]  ld_rd;
    logic [63:0] ld_data;
    logic [1:0]  ld_size;
    logic        ld_unsigned;
    logic        flush;
    logic        write_sig;
    logic [4:0]  write_reg;
    logic [63:0] write_val;
    logic [31:0] wb_count;

    modport master (
        output alu_valid, alu_rd, alu_val,
        output ld_valid, ld_rd, ld_data, ld_size, ld_unsigned, flush,
        input  alu_ready, ld_ready, write_sig, write_reg, write_val, wb_count
    );

    modport slave (
        input  alu_valid, alu_rd, alu_val,
        input  ld_valid, ld_rd, ld_data, ld_size, ld_unsigned, flush,
        output alu_ready, ld_ready, write_sig, write_reg, write_val, wb_count
    );
endinterface

// File: rtl/wb_arbiter.sv
// Two-source write-back arbiter: one holding register per source, load-priority with ALU anti-starvation.
// Define WB_LOAD_EXT_EN to size/sign-extend load data; otherwise ld_data is written unchanged.
module wb_arbiter (
    input  logic        clk,
    input  logic        reset,
    wb_arbiter_if.slave bus
);
    localparam logic [1:0] STARVE_LIMIT = 2'd2;

    logic        r_alu_vld;
    logic [4:0]  r_alu_rd;
    logic [63:0] r_alu_val;
    logic        r_ld_vld;
    logic [4:0]  r_ld_rd;
    logic [63:0] r_ld_val;
    logic [1:0]  r_starve_cnt;
    logic        r_write_sig;
    logic [4:0]  r_write_reg;
    logic [63:0] r_write_val;
    logic [31:0] r_wb_count;

    logic        w_grant_alu;
    logic        w_grant_ld;
    logic        w_grant_any;
    logic [4:0]  w_grant_rd;
    logic [63:0] w_grant_val;
    logic        w_write_next;
    logic        w_alu_fire;
    logic        w_ld_fire;
    logic [63:0] w_ld_value;

    // NOTE: every output of an always_comb gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_grant_alu = 1'b0;
        w_grant_ld  = 1'b0;
        if (!bus.flush) begin
            if (r_alu_vld && r_ld_vld) begin
                if (r_starve_cnt == STARVE_LIMIT) w_grant_alu = 1'b1;
                else                              w_grant_ld  = 1'b1;
            end else begin
                w_grant_alu = r_alu_vld;
                w_grant_ld  = r_ld_vld;
            end
        end
    end

    assign w_grant_any  = w_grant_alu || w_grant_ld;
    assign w_grant_rd   = w_grant_alu ? r_alu_rd  : r_ld_rd;
    assign w_grant_val  = w_grant_alu ? r_alu_val : r_ld_val;
    assign w_write_next = w_grant_any && (w_grant_rd != 5'd0);

    // Readies are gated by reset directly so they drop the instant reset asserts, not at the next edge.
    assign bus.alu_ready = reset && !bus.flush && (!r_alu_vld || w_grant_alu);
    assign bus.ld_ready  = reset && !bus.flush && (!r_ld_vld  || w_grant_ld);
    assign w_alu_fire    = bus.alu_valid && bus.alu_ready;
    assign w_ld_fire     = bus.ld_valid  && bus.ld_ready;

`ifdef WB_LOAD_EXT_EN
    always_comb begin
        w_ld_value = bus.ld_data;
        case (bus.ld_size)
            2'd0: w_ld_value = bus.ld_unsigned ? {56'd0, bus.ld_data[7:0]}
                                               : {{56{bus.ld_data[7]}}, bus.ld_data[7:0]};
            2'd1: w_ld_value = bus.ld_unsigned ? {48'd0, bus.ld_data[15:0]}
                                               : {{48{bus.ld_data[15]}}, bus.ld_data[15:0]};
            2'd2: w_ld_value = bus.ld_unsigned ? {32'd0, bus.ld_data[31:0]}
                                               : {{32{bus.ld_data[31]}}, bus.ld_data[31:0]};
            default: w_ld_value = bus.ld_data;
        endcase
    end
`else
    logic w_unused_ld_ext;
    assign w_ld_value      = bus.ld_data;
    assign w_unused_ld_ext = &{1'b0, bus.ld_size, bus.ld_unsigned};
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_alu_vld <= 1'b0;
            r_alu_rd  <= 5'd0;
            r_alu_val <= 64'd0;
        end else if (bus.flush) begin
            r_alu_vld <= 1'b0;
        end else if (w_alu_fire) begin
            r_alu_vld <= 1'b1;
            r_alu_rd  <= bus.alu_rd;
            r_alu_val <= bus.alu_val;
        end else if (w_grant_alu) begin
            r_alu_vld <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ld_vld <= 1'b0;
            r_ld_rd  <= 5'd0;
            r_ld_val <= 64'd0;
        end else if (bus.flush) begin
            r_ld_vld <= 1'b0;
        end else if (w_ld_fire) begin
            r_ld_vld <= 1'b1;
            r_ld_rd  <= bus.ld_rd;
            r_ld_val <= w_ld_value;
        end else if (w_grant_ld) begin
            r_ld_vld <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                                     r_starve_cnt <= 2'd0;
        else if (bus.flush || w_grant_alu || !r_alu_vld) r_starve_cnt <= 2'd0;
        else if (w_grant_ld)                            r_starve_cnt <= r_starve_cnt + 2'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_write_sig <= 1'b0;
            r_write_reg <= 5'd0;
            r_write_val <= 64'd0;
            r_wb_count  <= 32'd0;
        end else begin
            r_write_sig <= w_write_next;
            r_wb_count  <= r_wb_count + 32'(w_write_next);
            if (w_grant_any) begin
                r_write_reg <= w_grant_rd;
                r_write_val <= w_grant_val;
            end
        end
    end

    assign bus.write_sig = r_write_sig;
    assign bus.write_reg = r_write_reg;
    assign bus.write_val = r_write_val;
    assign bus.wb_count  = r_wb_count;
endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios plus a randomized run against a cycle model.
module tb_wb_arbiter;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    wb_arbiter_if bus ();

    wb_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Behavioural model: index 0 = ALU, 1 = load.
    logic        m_vld [2];
    logic [4:0]  m_rd  [2];
    logic [63:0] m_v   [2];
    int          m_losses;
    logic        m_sig;
    logic [4:0]  m_reg;
    logic [63:0] m_wval;
    logic [31:0] m_count;

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_vld[i] = 1'b0;
            m_rd[i]  = 5'd0;
            m_v[i]   = 64'd0;
        end
        m_losses = 0;
        m_sig    = 1'b0;
        m_reg    = 5'd0;
        m_wval   = 64'd0;
        m_count  = 32'd0;
    endfunction

    function automatic int winner();
        if (m_vld[0] && m_vld[1]) return (m_losses == 2) ? 0 : 1;
        if (m_vld[0]) return 0;
        if (m_vld[1]) return 1;
        return -1;
    endfunction

    function automatic logic exp_ready(int src);
        return !bus.flush && (!m_vld[src] || winner() == src);
    endfunction

    function automatic logic [63:0] load_value(logic [63:0] d, logic [1:0] sz, logic uns);
`ifdef WB_LOAD_EXT_EN
        int          nbits;
        logic [63:0] mask;
        if (sz == 2'd3) return d;
        nbits = 8 << sz;
        mask  = (64'd1 << nbits) - 64'd1;
        if (!uns && d[nbits-1]) return (d & mask) | ~mask;
        return d & mask;
`else
        return d;
`endif
    endfunction

    task automatic idle();
        bus.alu_valid   = 1'b0;
        bus.alu_rd      = 5'd0;
        bus.alu_val     = 64'd0;
        bus.ld_valid    = 1'b0;
        bus.ld_rd       = 5'd0;
        bus.ld_data     = 64'd0;
        bus.ld_size     = 2'd3;
        bus.ld_unsigned = 1'b0;
        bus.flush       = 1'b0;
    endtask

    // One clock edge; the model advances from the inputs held across the edge. Returns at edge + 1.
    task automatic tick();
        int   win;
        logic rdy0, rdy1, alu_was;
        @(posedge clk);
        rdy0    = exp_ready(0);
        rdy1    = exp_ready(1);
        win     = winner();
        alu_was = m_vld[0];
        if (bus.flush) begin
            m_vld[0] = 1'b0;
            m_vld[1] = 1'b0;
            m_losses = 0;
            m_sig    = 1'b0;
        end else begin
            m_sig = 1'b0;
            if (win >= 0) begin
                m_sig    = (m_rd[win] != 5'd0);
                m_reg    = m_rd[win];
                m_wval   = m_v[win];
                m_count  = m_count + 32'(m_sig);
                m_vld[win] = 1'b0;
            end
            if (win == 0 || !alu_was) m_losses = 0;
            else                      m_losses = m_losses + 1;
            if (bus.alu_valid && rdy0) begin
                m_vld[0] = 1'b1;
                m_rd[0]  = bus.alu_rd;
                m_v[0]   = bus.alu_val;
            end
            if (bus.ld_valid && rdy1) begin
                m_vld[1] = 1'b1;
                m_rd[1]  = bus.ld_rd;
                m_v[1]   = load_value(bus.ld_data, bus.ld_size, bus.ld_unsigned);
            end
        end
        #1;
    endtask

    task automatic test_reset();
        idle();
        bus.alu_valid = 1'b1;
        bus.ld_valid  = 1'b1;
        reset = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.alu_ready !== 1'b0) begin errors++; $display("FAIL reset_alu_ready: got %b want 0", bus.alu_ready); end
        checks++; if (bus.ld_ready !== 1'b0) begin errors++; $display("FAIL reset_ld_ready: got %b want 0", bus.ld_ready); end
        checks++; if (bus.write_sig !== 1'b0) begin errors++; $display("FAIL reset_write_sig: got %b want 0", bus.write_sig); end
        checks++; if (bus.write_reg !== 5'd0) begin errors++; $display("FAIL reset_write_reg: got %0d want 0", bus.write_reg); end
        checks++; if (bus.write_val !== 64'd0) begin errors++; $display("FAIL reset_write_val: got %h want 0", bus.write_val); end
        checks++; if (bus.wb_count !== 32'd0) begin errors++; $display("FAIL reset_wb_count: got %0d want 0", bus.wb_count); end
        idle();
        reset = 1'b1;
    endtask

    task automatic test_alu_single();
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd5;
        bus.alu_val   = 64'h1234;
        #1;
        checks++; if (bus.alu_ready !== 1'b1) begin errors++; $display("FAIL first_accept_ready: got %b want 1", bus.alu_ready); end
        tick();
        idle();
        checks++; if (bus.write_sig !== 1'b0) begin errors++; $display("FAIL alu_latency_early: got %b want 0", bus.write_sig); end
        tick();
        checks++; if (bus.write_sig !== 1'b1) begin errors++; $display("FAIL alu_write_sig: got %b want 1", bus.write_sig); end
        checks++; if (bus.write_reg !== 5'd5) begin errors++; $display("FAIL alu_write_reg: got %0d want 5", bus.write_reg); end
        checks++; if (bus.write_val !== 64'h1234) begin errors++; $display("FAIL alu_write_val: got %h want 1234", bus.write_val); end
        checks++; if (bus.wb_count !== 32'd1) begin errors++; $display("FAIL alu_wb_count: got %0d want 1", bus.wb_count); end
        tick();
        checks++; if (bus.write_sig !== 1'b0) begin errors++; $display("FAIL alu_single_pulse: got %b want 0", bus.write_sig); end
    endtask

    task automatic test_rd_zero();
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd0;
        bus.alu_val   = 64'hDEAD;
        tick();
        idle();
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (bus.write_sig !== 1'b0) begin errors++; $display("FAIL rd0_write_sig: cycle %0d got %b want 0", i, bus.write_sig); end
        end
        checks++; if (bus.wb_count !== 32'd1) begin errors++; $display("FAIL rd0_wb_count: got %0d want 1", bus.wb_count); end
    endtask

    task automatic test_arbitration();
        logic [4:0] exp_order [6];
        exp_order = '{5'd9, 5'd9, 5'd7, 5'd9, 5'd9, 5'd7};
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd7;
        bus.alu_val   = 64'hA1A1;
        bus.ld_valid  = 1'b1;
        bus.ld_rd     = 5'd9;
        bus.ld_data   = 64'hB2B2;
        bus.ld_size   = 2'd3;
        tick();
        for (int i = 0; i < 6; i++) begin
            checks++; if (bus.ld_ready !== exp_ready(1)) begin errors++; $display("FAIL arb_ld_ready: step %0d got %b want %b", i, bus.ld_ready, exp_ready(1)); end
            tick();
            checks++; if (bus.write_reg !== exp_order[i] || bus.write_sig !== 1'b1) begin
                errors++; $display("FAIL arb_order: step %0d got rd %0d sig %b want rd %0d sig 1", i, bus.write_reg, bus.write_sig, exp_order[i]);
            end
            checks++; if (dut.r_starve_cnt > 2'd2) begin errors++; $display("FAIL arb_starve_bound: got %0d want <= 2", dut.r_starve_cnt); end
        end
        idle();
        repeat (3) tick();
        checks++; if (bus.wb_count !== m_count) begin errors++; $display("FAIL arb_wb_count: got %0d want %0d", bus.wb_count, m_count); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 10; i++) begin
            bus.ld_valid = (i < 8);
            bus.ld_rd    = 5'($urandom_range(1, 31));
            bus.ld_data  = {$urandom, $urandom};
            bus.ld_size  = 2'd3;
            #1;
            checks++; if (bus.ld_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready: cycle %0d got %b want 1", i, bus.ld_ready); end
            tick();
            checks++; if (bus.write_sig !== m_sig || bus.write_reg !== m_reg || bus.write_val !== m_wval) begin
                errors++; $display("FAIL b2b_write: cycle %0d got sig %b rd %0d val %h want sig %b rd %0d val %h",
                                   i, bus.write_sig, bus.write_reg, bus.write_val, m_sig, m_reg, m_wval);
            end
        end
        idle();
        tick();
    endtask

    task automatic test_flush();
        logic [31:0] cnt_before;
        cnt_before    = m_count;
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd11;
        bus.alu_val   = 64'h1111;
        bus.ld_valid  = 1'b1;
        bus.ld_rd     = 5'd12;
        bus.ld_data   = 64'h2222;
        tick();
        bus.flush = 1'b1;
        #1;
        checks++; if (bus.alu_ready !== 1'b0 || bus.ld_ready !== 1'b0) begin
            errors++; $display("FAIL flush_ready_low: got alu %b ld %b want 0 0", bus.alu_ready, bus.ld_ready);
        end
        tick();
        idle();
        #1;
        checks++; if (bus.write_sig !== 1'b0) begin errors++; $display("FAIL flush_sig_edge1: got %b want 0", bus.write_sig); end
        checks++; if (bus.alu_ready !== 1'b1 || bus.ld_ready !== 1'b1) begin
            errors++; $display("FAIL flush_ready_return: got alu %b ld %b want 1 1", bus.alu_ready, bus.ld_ready);
        end
        tick();
        checks++; if (bus.write_sig !== 1'b0) begin errors++; $display("FAIL flush_sig_edge2: got %b want 0", bus.write_sig); end
        checks++; if (bus.wb_count !== cnt_before) begin errors++; $display("FAIL flush_wb_count: got %0d want %0d", bus.wb_count, cnt_before); end
    endtask

    task automatic test_load_ext();
        logic [63:0] exp_val [2];
        logic [63:0] data;
`ifdef WB_LOAD_EXT_EN
        data    = 64'h80;
        exp_val = '{64'hFFFF_FFFF_FFFF_FF80, 64'h80};
`else
        data    = 64'hA5A5_0000_0000_0080;
        exp_val = '{64'hA5A5_0000_0000_0080, 64'hA5A5_0000_0000_0080};
`endif
        for (int u = 0; u < 2; u++) begin
            bus.ld_valid    = 1'b1;
            bus.ld_rd       = 5'd3;
            bus.ld_data     = data;
            bus.ld_size     = 2'd0;
            bus.ld_unsigned = u[0];
            tick();
            idle();
            tick();
            checks++; if (bus.write_val !== exp_val[u] || bus.write_sig !== 1'b1) begin
                errors++; $display("FAIL load_ext: unsigned %0d got val %h sig %b want val %h sig 1", u, bus.write_val, bus.write_sig, exp_val[u]);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            bus.alu_valid   = ($urandom_range(0, 2) != 0);
            bus.alu_rd      = 5'($urandom_range(0, 31));
            bus.alu_val     = {$urandom, $urandom};
            bus.ld_valid    = ($urandom_range(0, 2) != 0);
            bus.ld_rd       = 5'($urandom_range(0, 31));
            bus.ld_data     = {$urandom, $urandom};
            bus.ld_size     = 2'($urandom_range(0, 3));
            bus.ld_unsigned = 1'($urandom_range(0, 1));
            bus.flush       = ($urandom_range(0, 19) == 0);
            #1;
            checks++; if (bus.alu_ready !== exp_ready(0) || bus.ld_ready !== exp_ready(1)) begin
                errors++; $display("FAIL rand_ready: cycle %0d got alu %b ld %b want alu %b ld %b",
                                   i, bus.alu_ready, bus.ld_ready, exp_ready(0), exp_ready(1));
            end
            tick();
            checks++; if (bus.write_sig !== m_sig || bus.write_reg !== m_reg || bus.write_val !== m_wval || bus.wb_count !== m_count) begin
                errors++; $display("FAIL rand_write: cycle %0d got sig %b rd %0d val %h cnt %0d want sig %b rd %0d val %h cnt %0d",
                                   i, bus.write_sig, bus.write_reg, bus.write_val, bus.wb_count, m_sig, m_reg, m_wval, m_count);
            end
        end
        idle();
        repeat (3) tick();
    endtask

    task automatic test_reset_mid();
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd4;
        bus.alu_val   = 64'h4444;
        tick();
        idle();
        bus.ld_valid = 1'b1;
        bus.ld_rd    = 5'd6;
        bus.ld_data  = 64'h6666;
        tick();
        bus.alu_valid = 1'b1;
        checks++; if (bus.write_sig !== 1'b1) begin errors++; $display("FAIL pre_reset_sig: got %b want 1", bus.write_sig); end
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        checks++; if (bus.write_sig !== 1'b0) begin errors++; $display("FAIL async_reset_sig: got %b want 0", bus.write_sig); end
        checks++; if (bus.wb_count !== 32'd0) begin errors++; $display("FAIL async_reset_count: got %0d want 0", bus.wb_count); end
        checks++; if (bus.alu_ready !== 1'b0 || bus.ld_ready !== 1'b0) begin
            errors++; $display("FAIL async_reset_ready: got alu %b ld %b want 0 0", bus.alu_ready, bus.ld_ready);
        end
        idle();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (bus.write_sig !== 1'b0) begin errors++; $display("FAIL reset_discard: cycle %0d got %b want 0", i, bus.write_sig); end
        end
    endtask

    initial begin
        idle();
        test_reset();
        test_alu_single();
        test_rd_zero();
        test_arbitration();
        test_back_to_back();
        test_flush();
        test_load_ext();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
